// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM responder with a programmable number of wait states.
// Define AHB_SRAM_ERROR_RESP_EN for ERROR responses on out-of-range or misaligned transfers.
module ahb_sram_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        i_hclk,
    input  logic        i_hreset_n,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic [2:0]  i_hsize,
    input  logic        i_hwrite,
    input  logic [31:0] i_hwdata,
    output logic [31:0] o_hrdata,
    output logic        o_hready,
    output logic        o_hresp
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StLast,
        StErr1,
        StErr2
    } state_e;

    localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e            r_state;
    logic              r_hready;
    logic              r_hresp;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_lane;
    logic [2:0]        r_size;
    logic              r_write;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_err;
    logic [3:0]        w_be;
    logic              w_unused;

    assign w_accept = i_hsel && i_htrans[1] && r_hready;
    assign w_unused = ^{i_haddr, i_htrans[0]};

`ifdef AHB_SRAM_ERROR_RESP_EN
    logic w_oor;
    // Any offset bit above the word index within the 28-bit slot is out of range.
    assign w_oor = (i_haddr[27:0] >> (ADDR_W + 2)) != 28'd0;
    assign w_err = w_oor || (i_hsize > 3'd2) ||
                   ((i_hsize == 3'd1) && i_haddr[0]) ||
                   ((i_hsize == 3'd2) && (i_haddr[1:0] != 2'b00));
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge i_hclk) begin
        if (!i_hreset_n) begin
            r_state  <= StIdle;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_lane   <= 2'b00;
            r_size   <= 3'd0;
            r_write  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StLast, StErr2: begin
                    if (w_accept) begin
                        r_idx   <= i_haddr[ADDR_W+1:2];
                        r_lane  <= i_haddr[1:0];
                        r_size  <= i_hsize;
                        r_write <= i_hwrite;
                        if (w_err) begin
                            r_state  <= StErr1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            r_state  <= StWait;
                            r_cnt    <= WaitLoad;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b0;
                        end else begin
                            r_state  <= StLast;
                            r_hready <= 1'b1;
                            r_hresp  <= 1'b0;
                        end
                    end else begin
                        r_state  <= StIdle;
                        r_hready <= 1'b1;
                        r_hresp  <= 1'b0;
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= StLast;
                        r_hready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StErr1: begin
                    r_state  <= StErr2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                default: begin
                    r_state  <= StIdle;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            3'd0:    w_be[r_lane] = 1'b1;
            3'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Commit at the edge that closes LAST; a reset on that edge discards the write.
    always_ff @(posedge i_hclk) begin
        if (i_hreset_n && (r_state == StLast) && r_write) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[r_idx][8*k +: 8] <= i_hwdata[8*k +: 8];
                end
            end
        end
    end

    assign o_hrdata = ((r_state == StLast) && !r_write) ? r_mem[r_idx] : 32'h0;
    assign o_hready = r_hready;
    assign o_hresp  = r_hresp;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances with 0, 2 and 3 wait states on a shared bus.
// Checks follow AHB_SRAM_ERROR_RESP_EN when the build defines it.
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel0, sel2, sel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] rd0, rd2, rd3;
    logic        rdy0, rdy2, rdy3;
    logic        rsp0, rsp2, rsp3;

    int n_chk = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(sel0), .i_haddr(haddr), .i_htrans(htrans),
        .i_hsize(hsize), .i_hwrite(hwrite), .i_hwdata(hwdata),
        .o_hrdata(rd0), .o_hready(rdy0), .o_hresp(rsp0)
    );

    ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(sel2), .i_haddr(haddr), .i_htrans(htrans),
        .i_hsize(hsize), .i_hwrite(hwrite), .i_hwdata(hwdata),
        .o_hrdata(rd2), .o_hready(rdy2), .o_hresp(rsp2)
    );

    ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(sel3), .i_haddr(haddr), .i_htrans(htrans),
        .i_hsize(hsize), .i_hwrite(hwrite), .i_hwdata(hwdata),
        .o_hrdata(rd3), .o_hready(rdy3), .o_hresp(rsp3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [2:0] sz, input logic wr);
        htrans = 2'b10;
        haddr  = a;
        hsize  = sz;
        hwrite = wr;
    endtask

    task automatic bus_idle();
        sel0   = 1'b0;
        sel2   = 1'b0;
        sel3   = 1'b0;
        htrans = 2'b00;
    endtask

    initial begin
        rst_n  = 1'b0;
        bus_idle();
        haddr  = 32'h0;
        hsize  = 3'd2;
        hwrite = 1'b0;
        hwdata = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chk("rst_hready0", 32'(rdy0), 32'd1);
        chk("rst_hresp0", 32'(rsp0), 32'd0);
        chk("rst_hrdata0", rd0, 32'h0);
        chk("rst_hready2", 32'(rdy2), 32'd1);

        // Selected but htrans IDLE: nothing accepted.
        sel0 = 1'b1;
        haddr = 32'h10;
        tick();
        chk("idle_trans_hready", 32'(rdy0), 32'd1);
        chk("idle_trans_hrdata", rd0, 32'h0);

        // Zero-wait word write then pipelined read of 0x10.
        addr_phase(32'h10, 3'd2, 1'b1);
        tick();
        chk("ws0_wr_hready", 32'(rdy0), 32'd1);
        hwdata = 32'hDEADBEEF;
        addr_phase(32'h10, 3'd2, 1'b0);
        tick();
        chk("ws0_rd_data", rd0, 32'hDEADBEEF);
        chk("ws0_rd_hready", 32'(rdy0), 32'd1);
        bus_idle();
        tick();
        chk("ws0_idle_hrdata", rd0, 32'h0);

        // Byte, byte, halfword writes then word read, all pipelined.
        sel0 = 1'b1;
        addr_phase(32'h20, 3'd0, 1'b1);
        tick();
        hwdata = 32'hEEEEEE11;
        addr_phase(32'h21, 3'd0, 1'b1);
        tick();
        hwdata = 32'hEEEE22EE;
        addr_phase(32'h22, 3'd1, 1'b1);
        tick();
        hwdata = 32'hBBAAEEEE;
        addr_phase(32'h20, 3'd2, 1'b0);
        tick();
        chk("lanes_rd", rd0, 32'hBBAA2211);

        // Back-to-back write then read of 0x40.
        addr_phase(32'h40, 3'd2, 1'b1);
        tick();
        hwdata = 32'h12345678;
        addr_phase(32'h40, 3'd2, 1'b0);
        tick();
        chk("b2b_rd", rd0, 32'h12345678);
        bus_idle();
        tick();

        // Two-wait instance: write 0x10, then timed read.
        sel2 = 1'b1;
        addr_phase(32'h10, 3'd2, 1'b1);
        tick();
        bus_idle();
        hwdata = 32'hDEADBEEF;
        n = 0;
        while (rdy2 !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        tick();
        sel2 = 1'b1;
        addr_phase(32'h10, 3'd2, 1'b0);
        tick();
        bus_idle();
        chk("ws2_wait_hready", 32'(rdy2), 32'd0);
        chk("ws2_wait_hrdata", rd2, 32'h0);
        n = 0;
        while (rdy2 !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("ws2_wait_len", 32'(n), 32'd2);
        chk("ws2_rd_data", rd2, 32'hDEADBEEF);
        tick();
        chk("ws2_after_hrdata", rd2, 32'h0);
        chk("ws2_after_hready", 32'(rdy2), 32'd1);

        // Three-wait instance: write 0x44, then reset during the WAIT of an overwrite.
        sel3 = 1'b1;
        addr_phase(32'h44, 3'd2, 1'b1);
        tick();
        bus_idle();
        hwdata = 32'hCAFEF00D;
        n = 0;
        while (rdy3 !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("ws3_wr_wait_len", 32'(n), 32'd3);
        tick();
        sel3 = 1'b1;
        addr_phase(32'h44, 3'd2, 1'b1);
        tick();
        bus_idle();
        hwdata = 32'h0BADC0DE;
        tick();
        chk("ws3_in_wait", 32'(rdy3), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_hready", 32'(rdy3), 32'd1);
        chk("mid_rst_hresp", 32'(rsp3), 32'd0);
        chk("mid_rst_hrdata", rd3, 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        sel3 = 1'b1;
        addr_phase(32'h44, 3'd2, 1'b0);
        tick();
        bus_idle();
        n = 0;
        while (rdy3 !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("ws3_rd_wait_len", 32'(n), 32'd3);
        chk("ws3_rd_prior", rd3, 32'hCAFEF00D);
        tick();

        // Out-of-range word write at 0x1000 against mem[0].
        sel0 = 1'b1;
        addr_phase(32'h0, 3'd2, 1'b1);
        tick();
        hwdata = 32'h55AA55AA;
        addr_phase(32'h1000, 3'd2, 1'b1);
        tick();
        hwdata = 32'h99999999;
`ifdef AHB_SRAM_ERROR_RESP_EN
        chk("err1_hready", 32'(rdy0), 32'd0);
        chk("err1_hresp", 32'(rsp0), 32'd1);
        htrans = 2'b00;
        tick();
        chk("err2_hready", 32'(rdy0), 32'd1);
        chk("err2_hresp", 32'(rsp0), 32'd1);
        chk("err2_hrdata", rd0, 32'h0);
`else
        chk("oor_hready", 32'(rdy0), 32'd1);
        chk("oor_hresp", 32'(rsp0), 32'd0);
`endif
        addr_phase(32'h0, 3'd2, 1'b0);
        tick();
`ifdef AHB_SRAM_ERROR_RESP_EN
        chk("err_mem0_kept", rd0, 32'h55AA55AA);
`else
        chk("alias_mem0_written", rd0, 32'h99999999);
`endif
        chk("final_hresp", 32'(rsp0), 32'd0);
        bus_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-lite responder: single-port word-organised SRAM behind one slave slot of the AHB bridge (hsel_sN, shared haddr_s/hsize_s/hwdata_s/hwrite_s).
- Accepts an address phase, inserts a programmable number of wait states, then completes the data phase.
- Supports byte, halfword and word writes, and drives the hrdata/hready pair the bridge muxes back to the master.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, >= 4.
- ADDR_W, $clog2(DEPTH), word-index width; derived, not overridden.
- WAIT_STATES, 0, hready-low cycles per data phase; range 0..15.

Ports:
- hclk  in  1  clock; all logic on rising edge.
- hreset_n  in  1  reset, synchronous and active-low.
- hsel  in  1  slave select from bridge decode.
- haddr  in  32  byte address; bits [27:0] are the offset in this slot.
- htrans  in  2  transfer type; 2'b10 NONSEQ, 2'b11 SEQ = valid.
- hsize  in  3  0 = byte, 1 = halfword, 2 = word.
- hwrite  in  1  1 = write.
- hwdata  in  32  write data, valid in the data phase.
- hrdata  out  32  read data.
- hready  out  1  transfer complete / slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (hreset_n = 0 at a rising edge):
  - state = IDLE, hready = 1, hresp = 0, hrdata = 0, wait counter = 0.
  - Any pending write is discarded. Memory contents are not reset.
  - Applies identically mid-transfer.
- Accept:
  - Condition: hsel = 1 && htrans[1] = 1 && hready = 1 (own hready) at a rising edge.
  - On accept, latch haddr, hsize and hwrite into the address register.
- Word index: haddr[ADDR_W+1:2]. Byte lane: haddr[1:0].
- States:
  - IDLE: hready = 1, hresp = 0. Accept -> WAIT if WAIT_STATES > 0, else LAST.
  - WAIT: hready = 0. Counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 -> LAST.
  - LAST: hready = 1, hresp = 0.
    - Write: at the closing edge, commit hwdata lanes to mem per latched size and lane.
    - Read: hrdata = mem[latched index] (combinational read of the array).
    - Next state: accept -> WAIT or LAST (pipelined back-to-back), else IDLE.
  - ERR1 / ERR2: see Optional Feature.
- Write lanes:
  - Byte: lane haddr[1:0].
  - Halfword: lanes {1,0} if haddr[1] = 0, else {3,2}.
  - Word: all 4 lanes.
  - Each enabled lane writes hwdata[8*k+7:8*k].
- hrdata = 32'h0 in every cycle except LAST of a read. Full word is returned regardless of size.
- Back-to-back write then read to the same word: the read data phase returns the newly written value (write commits at the edge ending LAST).
- htrans = IDLE/BUSY or hsel = 0 while hready = 1: no state change, OKAY response.
- Without the macro:
  - Offset bits [27:ADDR_W+2] are ignored, so addresses alias (wrap modulo DEPTH).
  - hsize > 2 is treated as word; misaligned addresses use the lane rules above.
- Latency: data phase lasts WAIT_STATES+1 cycles. Zero-wait throughput is one transfer per cycle.

Optional Feature:
- Macro: AHB_SRAM_ERROR_RESP_EN.
- Defined: an accepted transfer is flagged in error if any of the following holds:
  - offset bits [27:ADDR_W+2] are non-zero (out of range);
  - hsize > 2;
  - halfword with haddr[0] = 1;
  - word with haddr[1:0] != 0.
- A flagged transfer goes to ERR1 instead of WAIT/LAST, with no wait states and no memory write.
  - ERR1: hready = 0, hresp = 1, then -> ERR2.
  - ERR2: hready = 1, hresp = 1; accept is allowed, same as in LAST.
  - hrdata = 0 throughout.
- Undefined: hresp is constant 0, ERR1/ERR2 are unreachable, and the aliasing rules above apply.

Test Plan:
- WAIT_STATES = 0: write word 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> hready stays 1; the read data phase returns 0xDEADBEEF.
- WAIT_STATES = 2: read 0x0000_0010 -> hready = 0 for exactly 2 cycles, then 1 for one cycle with hrdata = 0xDEADBEEF.
- Byte writes 0x11 @0x20, 0x22 @0x21 and halfword 0xBBAA @0x22, then word read @0x20 -> 0xBBAA2211.
- Pipelined write 0x12345678 @0x40 immediately followed by read @0x40 (WAIT_STATES = 0) -> read returns 0x12345678 in the next cycle.
- Reset asserted during WAIT of a write to 0x44 (WAIT_STATES = 3) -> next cycle hready = 1, hresp = 0, hrdata = 0; a later read of 0x44 returns the prior contents.
- With AHB_SRAM_ERROR_RESP_EN, DEPTH = 1024: word write to 0x0000_1000 -> ERR1 (hready = 0, hresp = 1), then ERR2 (hready = 1, hresp = 1); mem[0] is unchanged. Without the macro: OKAY, and mem[0] is written.
